// File: rtl/ws2811_strip_sequencer.sv
// rtl/ws2811_strip_sequencer.sv - WS2811 strip frame sequencer: pattern ROM walk, swap/scale, tx handshake
module ws2811_strip_sequencer #(
    parameter int CLOCK_SPEED           = 50_000_000,
    parameter int UPDATES_PER_SECOND    = 20,
    parameter int UNITS_NUMBER          = 100,
    parameter int PATTERN_COLORS_NUMBER = 128,
    parameter int PATTERNS_NUMBER       = 4,
    parameter int MAX_SPEED             = 4,
    localparam int CW = $clog2(PATTERN_COLORS_NUMBER),
    localparam int PW = (PATTERNS_NUMBER > 1) ? $clog2(PATTERNS_NUMBER) : 1
) (
    input  logic           clkIN,
    input  logic           nResetIN,
    input  logic           cmdValidIN,
    input  logic [2:0]     cmdIN,
    output logic [PW+CW-1:0] romAddrOUT,
    input  logic [23:0]    romDataIN,
    output logic [23:0]    pixelDataOUT,
    output logic           txStartOUT,
    input  logic           txBusyIN,
    output logic           frameActiveOUT,
    output logic           overrunOUT
);

    localparam int TICK_CYCLES = CLOCK_SPEED / UPDATES_PER_SECOND;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int UW = $clog2(UNITS_NUMBER + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DATA,
        S_SEND,
        S_HOLD,
        S_WAITDONE
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [TW-1:0]  r_tick_cnt;
    logic           w_tick;

    // live settings, edited by commands at any time
    logic           r_pause;
    logic           r_dir;
    logic [PW-1:0]  r_pattern;
    logic [2:0]     r_swap;
    logic [2:0]     r_bright;
    logic [CW-1:0]  r_speed;

    // per-frame copies, frozen at frame start
    logic [PW-1:0]  r_pat_f;
    logic [2:0]     r_swap_f;
    logic [2:0]     r_bright_f;

    logic [CW-1:0]  r_shift;
    logic [CW-1:0]  r_idx;
    logic [UW-1:0]  r_count;
    logic [PW+CW-1:0] r_rom_addr;
    logic [23:0]    r_pixel;
    logic           r_overrun;

    logic [CW-1:0]  w_colour;
    logic [23:0]    w_swapped;
    logic [23:0]    w_scaled;
    logic           w_tx_start;
    logic           w_frame_active;

    assign w_tick   = (r_tick_cnt == TW'(TICK_CYCLES - 1));
    assign w_colour = r_idx + r_shift;

    assign romAddrOUT     = r_rom_addr;
    assign pixelDataOUT   = r_pixel;
    assign txStartOUT     = w_tx_start;
    assign frameActiveOUT = w_frame_active;
    assign overrunOUT     = r_overrun;

    // byte * (bright + 1) / 8; bright 7 passes the byte through unchanged
    function automatic logic [7:0] scale_byte(input logic [7:0] v, input logic [2:0] b);
        logic [10:0] p;
        p = {3'b000, v} * {7'b0000000, ({1'b0, b} + 4'd1)};
        return p[10:3];
    endfunction

    // free-running frame tick divider
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // command decode into live settings; swap opcodes edit speed while paused
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_pause   <= 1'b0;
            r_dir     <= 1'b0;
            r_pattern <= '0;
            r_swap    <= 3'd0;
            r_bright  <= 3'd7;
            r_speed   <= CW'(1);
        end else if (cmdValidIN) begin
            case (cmdIN)
                3'd0: r_pause <= ~r_pause;
                3'd1: r_dir <= ~r_dir;
                3'd2: r_pattern <= r_pattern + PW'(1);
                3'd3: r_pattern <= r_pattern - PW'(1);
                3'd4: begin
                    if (r_pause) begin
                        if (r_speed != CW'(MAX_SPEED)) begin
                            r_speed <= r_speed + CW'(1);
                        end
                    end else begin
                        r_swap <= (r_swap == 3'd5) ? 3'd0 : r_swap + 3'd1;
                    end
                end
                3'd5: begin
                    if (r_pause) begin
                        if (r_speed != CW'(1)) begin
                            r_speed <= r_speed - CW'(1);
                        end
                    end else begin
                        r_swap <= (r_swap == 3'd0) ? 3'd5 : r_swap - 3'd1;
                    end
                end
                3'd6: begin
                    if (r_bright != 3'd7) begin
                        r_bright <= r_bright + 3'd1;
                    end
                end
                default: begin
                    if (r_bright != 3'd0) begin
                        r_bright <= r_bright - 3'd1;
                    end
                end
            endcase
        end
    end

    // channel reorder of {A,B,C} selected by the frame's swap code
    always_comb begin
        w_swapped = romDataIN;
        case (r_swap_f)
            3'd0: w_swapped = {romDataIN[23:16], romDataIN[15:8],  romDataIN[7:0]};
            3'd1: w_swapped = {romDataIN[23:16], romDataIN[7:0],   romDataIN[15:8]};
            3'd2: w_swapped = {romDataIN[15:8],  romDataIN[23:16], romDataIN[7:0]};
            3'd3: w_swapped = {romDataIN[15:8],  romDataIN[7:0],   romDataIN[23:16]};
            3'd4: w_swapped = {romDataIN[7:0],   romDataIN[23:16], romDataIN[15:8]};
            3'd5: w_swapped = {romDataIN[7:0],   romDataIN[15:8],  romDataIN[23:16]};
            default: w_swapped = romDataIN;
        endcase
    end

    // brightness scaling applied after the swap
    always_comb begin
        w_scaled = {scale_byte(w_swapped[23:16], r_bright_f),
                    scale_byte(w_swapped[15:8],  r_bright_f),
                    scale_byte(w_swapped[7:0],   r_bright_f)};
    end

    // sequencer state register
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and handshake outputs
    always_comb begin
        w_next         = r_state;
        w_tx_start     = 1'b0;
        w_frame_active = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_frame_active = 1'b0;
                if (w_tick) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: w_next = S_DATA;
            S_DATA:  w_next = S_SEND;
            S_SEND: begin
                w_tx_start = 1'b1;
                w_next     = S_HOLD;
            end
            S_HOLD:  w_next = S_WAITDONE;
            S_WAITDONE: begin
                if (!txBusyIN) begin
                    w_next = (r_count != '0) ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                w_frame_active = 1'b0;
                w_next         = S_IDLE;
            end
        endcase
    end

    // frame datapath: latch settings at frame start, walk the ROM, register pixels
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            r_pat_f    <= '0;
            r_swap_f   <= 3'd0;
            r_bright_f <= 3'd7;
            r_shift    <= '0;
            r_idx      <= '0;
            r_count    <= '0;
            r_rom_addr <= '0;
            r_pixel    <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= w_tick && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_pat_f    <= r_pattern;
                        r_swap_f   <= r_swap;
                        r_bright_f <= r_bright;
                        if (!r_pause) begin
                            r_shift <= r_dir ? (r_shift - r_speed) : (r_shift + r_speed);
                        end
                        r_idx   <= '0;
                        r_count <= UW'(UNITS_NUMBER);
                    end
                end
                S_FETCH: r_rom_addr <= {r_pat_f, w_colour};
                S_DATA:  r_pixel <= w_scaled;
                S_SEND: begin
                    r_idx   <= r_idx + CW'(1);
                    r_count <= r_count - UW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2811_strip_sequencer.sv
// tb/tb_ws2811_strip_sequencer.sv - directed self-checking bench for ws2811_strip_sequencer
module tb_ws2811_strip_sequencer;

    logic        clkIN = 1'b0;
    logic        nResetIN;
    logic        cmdValidIN;
    logic [2:0]  cmdIN;
    logic [8:0]  romAddrOUT;
    logic [23:0] romDataIN;
    logic [23:0] pixelDataOUT;
    logic        txStartOUT;
    logic        txBusyIN = 1'b0;
    logic        frameActiveOUT;
    logic        overrunOUT;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        rom_fixed = 1'b0;
    logic        long_pending = 1'b0;
    int          busy_cnt = 0;
    logic        prev_start = 1'b0;
    int          ovr_cnt = 0;
    logic [23:0] pix_q[$];
    logic [6:0]  s;

    ws2811_strip_sequencer #(
        .CLOCK_SPEED(600),
        .UPDATES_PER_SECOND(10),
        .UNITS_NUMBER(3),
        .PATTERN_COLORS_NUMBER(128),
        .PATTERNS_NUMBER(4),
        .MAX_SPEED(4)
    ) dut (
        .clkIN(clkIN),
        .nResetIN(nResetIN),
        .cmdValidIN(cmdValidIN),
        .cmdIN(cmdIN),
        .romAddrOUT(romAddrOUT),
        .romDataIN(romDataIN),
        .pixelDataOUT(pixelDataOUT),
        .txStartOUT(txStartOUT),
        .txBusyIN(txBusyIN),
        .frameActiveOUT(frameActiveOUT),
        .overrunOUT(overrunOUT)
    );

    always #5 clkIN = ~clkIN;

    assign romDataIN = rom_fixed ? 24'h112233 : {8'hA5, 7'h00, romAddrOUT};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // transmitter model: busy rises the cycle after a start, then stays high for a while
    always @(negedge clkIN) begin
        if (!nResetIN) begin
            prev_start = 1'b0;
            busy_cnt   = 0;
        end else begin
            if (prev_start) begin
                busy_cnt     = long_pending ? 50 : 5;
                long_pending = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            prev_start = txStartOUT;
            if (txStartOUT) pix_q.push_back(pixelDataOUT);
            if (overrunOUT) ovr_cnt++;
        end
        txBusyIN = (busy_cnt > 0);
    end

    task automatic send_cmd(input logic [2:0] op);
        @(negedge clkIN);
        cmdValidIN = 1'b1;
        cmdIN      = op;
        @(negedge clkIN);
        cmdValidIN = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 200 && !frameActiveOUT; i++) @(negedge clkIN);
        check("frame_start", {31'd0, frameActiveOUT}, 32'd1);
        pix_q.delete();
    endtask

    task automatic wait_end();
        for (int i = 0; i < 400 && frameActiveOUT; i++) @(negedge clkIN);
        check("frame_end", {31'd0, frameActiveOUT}, 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [1:0] pat, input logic [6:0] shift);
        logic [6:0] c;
        check({tag, "_starts"}, pix_q.size(), 32'd3);
        for (int i = 0; i < 3 && i < pix_q.size(); i++) begin
            c = shift + 7'(i);
            check(tag, {8'd0, pix_q[i]}, {8'd0, 8'hA5, 7'h00, pat, c});
        end
    endtask

    task automatic check_fixed(input string tag, input logic [23:0] exp);
        check({tag, "_starts"}, pix_q.size(), 32'd3);
        for (int i = 0; i < 3 && i < pix_q.size(); i++) begin
            check(tag, {8'd0, pix_q[i]}, {8'd0, exp});
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr"},   {23'd0, romAddrOUT},    32'd0);
        check({tag, "_pixel"},  {8'd0, pixelDataOUT},   32'd0);
        check({tag, "_start"},  {31'd0, txStartOUT},    32'd0);
        check({tag, "_active"}, {31'd0, frameActiveOUT}, 32'd0);
        check({tag, "_ovr"},    {31'd0, overrunOUT},    32'd0);
    endtask

    initial begin
        nResetIN   = 1'b0;
        cmdValidIN = 1'b0;
        cmdIN      = 3'd0;
        repeat (3) @(negedge clkIN);
        check_outputs_zero("reset");
        nResetIN = 1'b1;

        // first frame: shift 1, default pattern/swap/bright
        wait_start();
        wait_end();
        check_frame("t1", 2'd0, 7'd1);

        // swap to 3 for the next frame
        wait_start();
        send_cmd(3'd4);
        send_cmd(3'd4);
        send_cmd(3'd4);
        wait_end();
        check_frame("f2", 2'd0, 7'd2);
        rom_fixed = 1'b1;

        // swap 3 visible; drop brightness to 3
        wait_start();
        repeat (4) send_cmd(3'd7);
        wait_end();
        check_fixed("swap3", 24'h223311);

        // bright 3 visible; restore bright/swap and pause
        wait_start();
        repeat (4) send_cmd(3'd6);
        repeat (3) send_cmd(3'd5);
        send_cmd(3'd0);
        wait_end();
        check_fixed("bright3", 24'h111908);
        rom_fixed = 1'b0;

        // paused: shift frozen at 4, speed edited to 3, swap untouched
        wait_start();
        send_cmd(3'd4);
        send_cmd(3'd4);
        wait_end();
        check_frame("pause1", 2'd0, 7'd4);
        wait_start();
        wait_end();
        check_frame("pause2", 2'd0, 7'd4);
        wait_start();
        send_cmd(3'd0);
        wait_end();
        check_frame("pause3", 2'd0, 7'd4);

        // unpaused at speed 3: 7, 10, ... 127, then wrap to 2
        s = 7'd7;
        repeat (42) begin
            wait_start();
            wait_end();
            check_frame("speed3", 2'd0, s);
            s = s + 7'd3;
        end
        check("wrap_shift", {25'd0, s}, 32'd5);

        // long busy on the first pixel spans a tick: one overrun, frame still completes
        long_pending = 1'b1;
        wait_start();
        wait_end();
        check_frame("overrun", 2'd0, 7'd5);
        check("ovr_pulses", ovr_cnt, 32'd1);

        // reset while waiting on the transmitter
        wait_start();
        for (int i = 0; i < 50 && pix_q.size() == 0; i++) @(negedge clkIN);
        repeat (2) @(negedge clkIN);
        check("pre_reset_active", {31'd0, frameActiveOUT}, 32'd1);
        nResetIN = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(negedge clkIN);
        nResetIN = 1'b1;
        pix_q.delete();

        // fresh frame after reset; then reverse direction and step pattern down from 0
        wait_start();
        send_cmd(3'd1);
        send_cmd(3'd3);
        wait_end();
        check_frame("fresh", 2'd0, 7'd1);
        wait_start();
        wait_end();
        check_frame("dir0", 2'd3, 7'd0);
        wait_start();
        wait_end();
        check_frame("dir127", 2'd3, 7'd127);
        check("ovr_total", ovr_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
